// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator quad.
// Slot-0 config layout, FSM encoding and saturation helper.
package cnn_layer_accel_pkg;

    localparam int C_LANES      = 8;
    localparam int C_WBUF_DEPTH = 32;
    localparam int C_LANE_W     = 16;
    localparam int C_ACC_W      = 40;

    localparam int F_ROWS_LSB   = 0;
    localparam int F_COLS_LSB   = 16;
    localparam int F_KSIZE_LSB  = 32;
    localparam int F_STRIDE_LSB = 36;
    localparam int F_PAD_LSB    = 40;
    localparam int F_UPS_BIT    = 48;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        FETCH_REQ,
        LOAD_W,
        COMPUTE,
        RESULT,
        DONE
    } state_t;

    typedef struct packed {
        logic [15:0] rows;
        logic [15:0] cols;
        logic [3:0]  ksize;
        logic [3:0]  stride;
        logic [3:0]  pad;
        logic        ups;
    } cfg_t;

    function automatic cfg_t unpack_cfg(input logic [127:0] w);
        cfg_t c;
        c.rows   = w[F_ROWS_LSB +: 16];
        c.cols   = w[F_COLS_LSB +: 16];
        c.ksize  = w[F_KSIZE_LSB +: 4];
        c.stride = w[F_STRIDE_LSB +: 4];
        c.pad    = w[F_PAD_LSB +: 4];
        c.ups    = w[F_UPS_BIT];
        return c;
    endfunction

    function automatic logic [15:0] sat16(input logic signed [C_ACC_W-1:0] v);
        if (v > 40'sd32767)
            return 16'h7fff;
        if (v < -40'sd32768)
            return 16'h8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/cnn_layer_accel_mac8.sv
// Combinational lane-wise 16x16 signed multiply with adder tree.
// Produces a 40-bit signed sum of all lane products.
module cnn_layer_accel_mac8 #(
    parameter int C_LANES = 8
) (
    input  logic [C_LANES*16-1:0] pixel_data,
    input  logic [C_LANES*16-1:0] weight_data,
    output logic signed [39:0]    sum
);

    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] prod;

    always_comb begin
        sum  = '0;
        a    = '0;
        b    = '0;
        prod = '0;
        for (int i = 0; i < C_LANES; i++) begin
            a    = pixel_data[i*16 +: 16];
            b    = weight_data[i*16 +: 16];
            prod = a * b;
            sum  = sum + {{8{prod[31]}}, prod};
        end
    end

endmodule

// File: rtl/cnn_layer_accel_quad.sv
// Single-job CNN layer engine: config, weight load, windowed MAC,
// saturated per-window results and a combinational cascade bypass.
module cnn_layer_accel_quad #(
    parameter int C_LANES      = 8,
    parameter int C_WBUF_DEPTH = 32
) (
    input  logic         clk_core,
    input  logic         rst,
    input  logic         job_start,
    output logic         job_accept,
    input  logic [127:0] job_parameters,
    output logic         job_fetch_request,
    input  logic         job_fetch_ack,
    output logic         job_fetch_complete,
    output logic         job_complete,
    input  logic         job_complete_ack,
    input  logic [3:0]   config_valid,
    output logic [3:0]   config_accept,
    input  logic [127:0] config_data,
    input  logic         weight_valid,
    output logic         weight_ready,
    input  logic [127:0] weight_data,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    input  logic [127:0] pixel_data,
    output logic         result_valid,
    input  logic         result_accept,
    output logic [15:0]  result_data,
    input  logic         cascade_in_valid,
    output logic         cascade_in_ready,
    input  logic [127:0] cascade_in_data,
    output logic         cascade_out_valid,
    input  logic         cascade_out_ready,
    output logic [127:0] cascade_out_data
);

    import cnn_layer_accel_pkg::*;

    localparam int IDX_W = $clog2(C_WBUF_DEPTH);

    state_t state;
    state_t state_next;
    cfg_t   cfg_in;

    logic [3:0]   kernel_size_cfg;
    logic [7:0]   kernel_full_count_cfg;
    logic [3:0]   convolution_stride_cfg;
    logic [3:0]   padding_cfg;
    logic         upsample_cfg;
    logic [15:0]  num_output_rows_cfg;
    logic [15:0]  num_output_cols_cfg;
    logic [31:0]  total_results_cfg;
    logic [127:0] job_param_q;

    logic [7:0]   w_cnt;
    logic [7:0]   p_cnt;
    logic [31:0]  res_cnt;
    logic signed [C_ACC_W-1:0] acc;
    logic signed [C_ACC_W-1:0] mac_sum;
    logic signed [C_ACC_W-1:0] acc_sum;
    logic [15:0]  result_q;
    logic         accept_q;
    logic         fetch_done_q;
    logic [127:0] wbuf [C_WBUF_DEPTH];
    logic [127:0] wbuf_rd;
    logic [3:0]   ksize_eff;

    logic w_hs;
    logic p_hs;
    logic w_last;
    logic win_last;
    logic job_last;
    logic cfg_hs;

    assign cfg_in    = unpack_cfg(config_data);
    assign ksize_eff = (cfg_in.ksize == 4'd0) ? 4'd1 : cfg_in.ksize;
    assign cfg_hs    = (state == CONFIG) && config_valid[0];
    assign w_hs      = weight_valid && weight_ready;
    assign p_hs      = pixel_valid && pixel_ready;
    assign w_last    = (w_cnt == kernel_full_count_cfg - 8'd1);
    assign win_last  = (p_cnt == kernel_full_count_cfg - 8'd1);
    assign job_last  = win_last && (res_cnt == total_results_cfg - 32'd1);
    assign wbuf_rd   = wbuf[p_cnt[IDX_W-1:0]];
    assign acc_sum   = acc + mac_sum;

    cnn_layer_accel_mac8 #(
        .C_LANES(C_LANES)
    ) u_mac (
        .pixel_data (pixel_data),
        .weight_data(wbuf_rd),
        .sum        (mac_sum)
    );

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:
                if (job_start)
                    state_next = CONFIG;
            CONFIG:
                if (config_valid[0])
                    state_next = FETCH_REQ;
            FETCH_REQ:
                if (job_fetch_ack)
                    state_next = (num_output_rows_cfg == 16'd0 ||
                                  num_output_cols_cfg == 16'd0)
                               ? DONE : LOAD_W;
            LOAD_W:
                if (w_hs && w_last)
                    state_next = COMPUTE;
            COMPUTE:
                if (p_hs && win_last)
                    state_next = RESULT;
            RESULT:
                if (result_accept)
                    state_next = (res_cnt == total_results_cfg)
                               ? DONE : COMPUTE;
            DONE:
                if (job_complete_ack)
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // Readies derive from state alone, never from the matching valid.
    always_comb begin
        config_accept     = (state == CONFIG) ? 4'b1111 : 4'b0000;
        job_fetch_request = (state == FETCH_REQ);
        weight_ready      = (state == LOAD_W);
        pixel_ready       = (state == COMPUTE);
        result_valid      = (state == RESULT);
        job_complete      = (state == DONE);
    end

    assign job_accept         = accept_q;
    assign job_fetch_complete = fetch_done_q;
    assign result_data        = result_q;

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            accept_q               <= 1'b0;
            fetch_done_q           <= 1'b0;
            job_param_q            <= '0;
            kernel_size_cfg        <= '0;
            kernel_full_count_cfg  <= '0;
            convolution_stride_cfg <= '0;
            padding_cfg            <= '0;
            upsample_cfg           <= 1'b0;
            num_output_rows_cfg    <= '0;
            num_output_cols_cfg    <= '0;
            total_results_cfg      <= '0;
            w_cnt                  <= '0;
            p_cnt                  <= '0;
            res_cnt                <= '0;
            acc                    <= '0;
            result_q               <= '0;
        end else begin
            accept_q     <= (state == IDLE) && job_start;
            fetch_done_q <= p_hs && job_last;
            if ((state == IDLE) && job_start)
                job_param_q <= job_parameters;
            if (cfg_hs) begin
                kernel_size_cfg        <= ksize_eff;
                kernel_full_count_cfg  <= {4'd0, ksize_eff} * {4'd0, ksize_eff};
                convolution_stride_cfg <= cfg_in.stride;
                padding_cfg            <= cfg_in.pad;
                upsample_cfg           <= cfg_in.ups;
                num_output_rows_cfg    <= cfg_in.rows;
                num_output_cols_cfg    <= cfg_in.cols;
                total_results_cfg      <= {16'd0, cfg_in.rows} * {16'd0, cfg_in.cols};
                w_cnt                  <= '0;
                p_cnt                  <= '0;
                res_cnt                <= '0;
                acc                    <= '0;
            end
            if (w_hs)
                w_cnt <= w_cnt + 8'd1;
            if (p_hs) begin
                if (win_last) begin
                    p_cnt    <= '0;
                    acc      <= '0;
                    result_q <= sat16(acc_sum);
                    res_cnt  <= res_cnt + 32'd1;
                end else begin
                    p_cnt <= p_cnt + 8'd1;
                    acc   <= acc_sum;
                end
            end
        end
    end

    // Weight storage carries no reset; contents are rewritten every job.
    always_ff @(posedge clk_core) begin
        if (w_hs)
            wbuf[w_cnt[IDX_W-1:0]] <= weight_data;
    end

    assign cascade_out_valid = cascade_in_valid;
    assign cascade_out_data  = cascade_in_data;
    assign cascade_in_ready  = cascade_out_ready;

endmodule

// File: tb/tb_cnn_layer_accel_quad.sv
// Scoreboard bench for cnn_layer_accel_quad: window sums from a
// plain-arithmetic model are queued and matched as results appear.
module tb_cnn_layer_accel_quad;

    logic         clk_core = 1'b0;
    logic         rst;
    logic         job_start;
    logic         job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request;
    logic         job_fetch_ack;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack;
    logic [3:0]   config_valid;
    logic [3:0]   config_accept;
    logic [127:0] config_data;
    logic         weight_valid;
    logic         weight_ready;
    logic [127:0] weight_data;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [127:0] pixel_data;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         cascade_in_valid;
    logic         cascade_in_ready;
    logic [127:0] cascade_in_data;
    logic         cascade_out_valid;
    logic         cascade_out_ready;
    logic [127:0] cascade_out_data;

    always #5 clk_core = ~clk_core;

    cnn_layer_accel_quad dut (
        .clk_core          (clk_core),
        .rst               (rst),
        .job_start         (job_start),
        .job_accept        (job_accept),
        .job_parameters    (job_parameters),
        .job_fetch_request (job_fetch_request),
        .job_fetch_ack     (job_fetch_ack),
        .job_fetch_complete(job_fetch_complete),
        .job_complete      (job_complete),
        .job_complete_ack  (job_complete_ack),
        .config_valid      (config_valid),
        .config_accept     (config_accept),
        .config_data       (config_data),
        .weight_valid      (weight_valid),
        .weight_ready      (weight_ready),
        .weight_data       (weight_data),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .pixel_data        (pixel_data),
        .result_valid      (result_valid),
        .result_accept     (result_accept),
        .result_data       (result_data),
        .cascade_in_valid  (cascade_in_valid),
        .cascade_in_ready  (cascade_in_ready),
        .cascade_in_data   (cascade_in_data),
        .cascade_out_valid (cascade_out_valid),
        .cascade_out_ready (cascade_out_ready),
        .cascade_out_data  (cascade_out_data)
    );

    int tests = 0;
    int fails = 0;
    int pix_accepted = 0;
    int fc_count = 0;
    int fc_beat = 0;
    bit done = 1'b0;
    bit hold_mode = 1'b0;

    logic [127:0] w_beats[$];
    logic [127:0] p_beats[$];
    logic [15:0]  exp_q[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint lane(input logic [127:0] v, input int l);
        logic signed [15:0] x;
        x = v[l*16 +: 16];
        return longint'(x);
    endfunction

    function automatic logic [15:0] sat_model(input longint s);
        if (s > 32767)
            return 16'h7fff;
        if (s < -32768)
            return 16'h8000;
        return 16'(s);
    endfunction

    // Each window is a plain dot product of its pixel beats with the kernel.
    function automatic void build_expected(input int kfc);
        for (int win = 0; win < p_beats.size() / kfc; win++) begin
            longint s = 0;
            for (int b = 0; b < kfc; b++)
                for (int l = 0; l < 8; l++)
                    s += lane(p_beats[win*kfc + b], l) * lane(w_beats[b], l);
            exp_q.push_back(sat_model(s));
        end
    endfunction

    function automatic logic [127:0] beat_rand();
        logic [127:0] b;
        for (int l = 0; l < 8; l++)
            b[l*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                          : 16'($urandom_range(0, 600) - 300);
        return b;
    endfunction

    task automatic prep(input int kfc, input int nres, input int mode,
                        input logic [15:0] wv, input logic [15:0] pv);
        w_beats.delete();
        p_beats.delete();
        for (int i = 0; i < kfc; i++)
            w_beats.push_back(mode == 0 ? beat_rand() : {8{wv}});
        for (int i = 0; i < kfc * nres; i++)
            p_beats.push_back(mode == 0 ? beat_rand() : {8{pv}});
    endtask

    task automatic start_job(input int rows, input int cols, input int ks);
        logic [127:0] cfg;
        int kfc;
        kfc = (ks == 0) ? 1 : ks * ks;
        cfg = '0;
        cfg[15:0]  = 16'(rows);
        cfg[31:16] = 16'(cols);
        cfg[35:32] = 4'(ks);
        cfg[39:36] = 4'($urandom);
        cfg[43:40] = 4'($urandom);
        cfg[48]    = 1'($urandom);
        pix_accepted = 0;
        fc_count = 0;
        fc_beat = 0;
        @(posedge clk_core); #1;
        job_start = 1'b1;
        job_parameters = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk_core); #1;
        job_start = 1'b0;
        chk("job_accept_pulse", job_accept, 1);
        config_valid = 4'b0110;
        config_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk_core);
        chk("config_accept", config_accept, 4'hf);
        @(posedge clk_core); #1;
        chk("job_accept_single", job_accept, 0);
        config_valid = 4'b0001;
        config_data = cfg;
        @(posedge clk_core); #1;
        config_valid = 4'b0000;
        chk("kfc_cfg", dut.kernel_full_count_cfg, kfc);
        chk("rows_cfg", dut.num_output_rows_cfg, rows);
        repeat ($urandom_range(0, 3)) @(posedge clk_core);
        #1;
        chk("fetch_request", job_fetch_request, 1);
        job_fetch_ack = 1'b1;
        @(posedge clk_core); #1;
        job_fetch_ack = 1'b0;
    endtask

    task automatic load_weights(input int kfc);
        int idx = 0;
        int cyc = 0;
        while (idx < kfc && cyc < 500) begin
            weight_valid = ($urandom_range(0, 3) != 0);
            weight_data = w_beats[idx];
            @(negedge clk_core);
            if (weight_valid && weight_ready)
                idx++;
            @(posedge clk_core); #1;
            cyc++;
        end
        weight_valid = 1'b0;
        chk("weights_loaded", idx, kfc);
    endtask

    task automatic feed_pixels(input int stop);
        int cyc = 0;
        while (pix_accepted < stop && cyc < 20000) begin
            pixel_valid = ($urandom_range(0, 3) != 0);
            pixel_data = p_beats[pix_accepted];
            @(negedge clk_core);
            if (pixel_valid && pixel_ready)
                pix_accepted++;
            @(posedge clk_core); #1;
            cyc++;
        end
        pixel_valid = 1'b0;
        chk("pixels_accepted", pix_accepted, stop);
    endtask

    task automatic finish_job(input int nbeats);
        int cyc = 0;
        while (!job_complete && cyc < 2000) begin
            @(posedge clk_core); #1;
            cyc++;
        end
        chk("job_complete", job_complete, 1);
        chk("results_drained", exp_q.size(), 0);
        chk("fetch_complete_pulses", fc_count, (nbeats > 0) ? 1 : 0);
        if (nbeats > 0)
            chk("fetch_complete_beat", fc_beat, nbeats);
        job_complete_ack = 1'b1;
        @(posedge clk_core); #1;
        job_complete_ack = 1'b0;
        chk("complete_cleared", job_complete, 0);
    endtask

    task automatic run_job(input int rows, input int cols, input int ks);
        int kfc;
        int nres;
        kfc = (ks == 0) ? 1 : ks * ks;
        nres = rows * cols;
        build_expected(kfc);
        start_job(rows, cols, ks);
        if (nres > 0) begin
            load_weights(kfc);
            feed_pixels(nres * kfc);
        end
        finish_job(nres * kfc);
    endtask

    // Result monitor: owns result_accept, pops the scoreboard on handshake.
    initial begin
        logic [15:0] d0;
        int p0;
        result_accept = 1'b0;
        while (!done) begin
            @(posedge clk_core); #1;
            if (result_valid && hold_mode) begin
                hold_mode = 1'b0;
                result_accept = 1'b0;
                d0 = result_data;
                p0 = pix_accepted;
                repeat (10) begin
                    @(negedge clk_core);
                    chk("hold_valid", result_valid, 1);
                    chk("hold_data", result_data, d0);
                    chk("hold_pixel_ready", pixel_ready, 0);
                    chk("hold_no_beats", pix_accepted, p0);
                end
            end else begin
                result_accept = ($urandom_range(0, 2) != 0);
                @(negedge clk_core);
                if (result_valid && result_accept) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got %0h expected none",
                                 result_data);
                    end else begin
                        chk("result_data", result_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk_core);
            if (job_fetch_complete) begin
                fc_count++;
                fc_beat = pix_accepted;
            end
        end
    end

    initial begin
        cascade_in_valid = 1'b0;
        cascade_in_data = '0;
        cascade_out_ready = 1'b0;
        while (!done) begin
            @(negedge clk_core);
            cascade_in_valid = 1'($urandom);
            cascade_out_ready = ($urandom_range(0, 3) != 0);
            cascade_in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("cascade", {cascade_out_valid, cascade_in_ready, cascade_out_data},
                {cascade_in_valid, cascade_out_ready, cascade_in_data});
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] b;
        rst = 1'b1;
        job_start = 1'b0;
        job_parameters = '0;
        job_fetch_ack = 1'b0;
        job_complete_ack = 1'b0;
        config_valid = '0;
        config_data = '0;
        weight_valid = 1'b0;
        weight_data = '0;
        pixel_valid = 1'b0;
        pixel_data = '0;
        repeat (3) @(negedge clk_core);
        chk("rst_job_accept", job_accept, 0);
        chk("rst_config_accept", config_accept, 0);
        chk("rst_fetch_req", job_fetch_request, 0);
        chk("rst_fetch_complete", job_fetch_complete, 0);
        chk("rst_job_complete", job_complete, 0);
        chk("rst_weight_ready", weight_ready, 0);
        chk("rst_pixel_ready", pixel_ready, 0);
        chk("rst_result", {result_valid, result_data}, 0);
        chk("rst_kfc", dut.kernel_full_count_cfg, 0);
        @(posedge clk_core); #1;
        rst = 1'b0;

        // K=1, one window: weights 1, pixels 1..8 -> 36
        w_beats.delete();
        p_beats.delete();
        w_beats.push_back({8{16'd1}});
        for (int l = 0; l < 8; l++)
            b[l*16 +: 16] = 16'(l + 1);
        p_beats.push_back(b);
        run_job(1, 1, 1);

        // K=3, 2x2 outputs, weights 2, pixels 1
        prep(9, 4, 1, 16'd2, 16'd1);
        run_job(2, 2, 3);

        // Saturation in both directions
        prep(1, 1, 1, 16'h7fff, 16'h7fff);
        run_job(1, 1, 1);
        prep(1, 1, 1, 16'h8001, 16'h7fff);
        run_job(1, 1, 1);

        // Back-pressure on the first result
        prep(4, 3, 0, 16'd0, 16'd0);
        hold_mode = 1'b1;
        run_job(1, 3, 2);

        // Kernel size 0 behaves as 1
        prep(1, 2, 0, 16'd0, 16'd0);
        run_job(2, 1, 0);

        for (int j = 0; j < 6; j++) begin
            int ks;
            int r;
            int c;
            ks = $urandom_range(1, 5);
            r = $urandom_range(1, 3);
            c = $urandom_range(1, 3);
            prep(ks * ks, r * c, 0, 16'd0, 16'd0);
            run_job(r, c, ks);
        end

        // Reset in the middle of a compute phase
        prep(4, 4, 0, 16'd0, 16'd0);
        build_expected(4);
        start_job(2, 2, 2);
        load_weights(4);
        feed_pixels(6);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk_core);
        chk("midrst_pixel_ready", pixel_ready, 0);
        chk("midrst_result_valid", result_valid, 0);
        chk("midrst_job_complete", job_complete, 0);
        chk("midrst_acc", dut.acc, 0);
        chk("midrst_cfg", {dut.kernel_full_count_cfg, dut.num_output_rows_cfg}, 0);
        @(posedge clk_core); #1;
        rst = 1'b0;
        p_beats.delete();
        w_beats.delete();
        run_job(0, 3, 1);
        run_job(4, 0, 2);

        done = 1'b1;
        repeat (3) @(posedge clk_core);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
